// File: rtl/pe_bus_pkg.sv
// -----------------------------------------------------------------------------
// pe_bus_pkg
// Purpose : Shared types for the PE bus master: the transfer FSM state encoding
//           and the default request record queued between the PE and the bus.
// Ports   : none (package).
// Note    : pe_bus_master builds its own request record from its DATA_W/ADDR_W
//           parameters; pe_req_t is the record for the default 32/32 build.
// -----------------------------------------------------------------------------
package pe_bus_pkg;

    localparam int PE_DATA_W = 32;
    localparam int PE_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic                 write;
        logic [PE_ADDR_W-1:0] addr;
        logic [PE_DATA_W-1:0] wdata;
    } pe_req_t;

endpackage

// File: rtl/pe_req_fifo.sv
// -----------------------------------------------------------------------------
// pe_req_fifo
// Purpose : DEPTH-entry request queue holding PE load/store records until the
//           bus transfer for the head entry completes.
// Ports   : clk, reset (sync, active-high)
//           i_push / i_din  : enqueue, ignored while full
//           i_pop           : drop head entry, ignored while empty
//           o_dout          : head entry (valid while !o_empty)
//           o_full, o_empty : occupancy flags
//           o_count         : number of stored entries
// -----------------------------------------------------------------------------
module pe_req_fifo
    import pe_bus_pkg::*;
#(
    parameter type entry_t = pe_req_t,
    parameter int  DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  entry_t                     i_din,
    input  logic                       i_pop,
    output entry_t                     o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Full is taken from the registered count, so a pop in the same cycle
    // never frees a slot for a simultaneous push.
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
    // increment wraps modulo DEPTH on its own.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read after it
    // has been written, and leaving the array out of reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/pe_bus_master.sv
// -----------------------------------------------------------------------------
// pe_bus_master
// Purpose : Bus-side interface of one RISC-V PE. Queues PE load/store requests,
//           arbitrates for the shared CGRA bus (bus_request/grant), runs one
//           global-memory transfer at a time and returns a one-cycle response.
// Ports   : clk, reset (sync, active-high)
//           PE request  : req_valid, req_ready, req_write, req_addr, req_wdata
//           Arbiter     : bus_request, grant
//           Memory bus  : mem_address, mem_wdata, mem_read, mem_write,
//                         mem_ack, mem_rdata
//           PE response : rsp_valid, rsp_write, rsp_rdata, rsp_err
//           Status      : pending (queued + in-flight requests)
// Config  : define PE_BUS_TIMEOUT_EN to abort a transfer whose ack has not
//           arrived after TIMEOUT_CYCLES cycles in XFER (response with
//           rsp_err=1). Undefined: XFER waits for ack indefinitely, rsp_err=0.
// -----------------------------------------------------------------------------
module pe_bus_master
    import pe_bus_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       bus_request,
    input  logic                       grant,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_read,
    output logic                       mem_write,
    input  logic                       mem_ack,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       rsp_valid,
    output logic                       rsp_write,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pe_bus_master: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
    end

    state_t            r_state;
    state_t            w_next;
    req_t              w_din;
    req_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_done;
    logic              w_expired;
    logic              r_rsp_write;
    logic [DATA_W-1:0] r_rsp_rdata;

    assign req_ready = !w_full;
    assign w_din     = '{write: req_write, addr: req_addr, wdata: req_wdata};

    pe_req_fifo #(
        .entry_t (req_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (req_valid),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (pending)
    );

`ifdef PE_BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_rsp_err;

    // Held at zero outside XFER, so it is cleared on every entry; in the k-th
    // XFER cycle it reads k-1, hence expiry on the TIMEOUT_CYCLES-th cycle.
    always_ff @(posedge clk) begin
        if (reset || r_state != XFER) r_tmo_cnt <= '0;
        else                          r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign w_expired = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // An ack arriving together with expiry is a normal completion.
    always_ff @(posedge clk) begin
        if (reset)       r_rsp_err <= 1'b0;
        else if (w_done) r_rsp_err <= !mem_ack;
    end

    assign rsp_err = rsp_valid && r_rsp_err;
`else
    assign w_expired = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // NOTE: the state register uses <= so every flop samples pre-edge values;
    // all decode sits in the always_comb below with defaults first, so no
    // path through the case statement can leave a latch behind.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    assign w_done = (r_state == XFER) && (mem_ack || w_expired);

    always_comb begin
        w_next      = r_state;
        bus_request = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        rsp_valid   = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) w_next = REQ;
            end
            REQ: begin
                bus_request = 1'b1;
                if (grant) w_next = XFER;
            end
            XFER: begin
                // Grant may drop here; the transfer runs until ack (or timeout).
                bus_request = 1'b1;
                mem_address = w_head.addr;
                mem_wdata   = w_head.wdata;
                mem_read    = !w_head.write;
                mem_write   = w_head.write;
                if (w_done) begin
                    w_pop  = 1'b1;
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Response payload captured at completion; timed-out loads return 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else if (w_done) begin
            r_rsp_write <= w_head.write;
            r_rsp_rdata <= (mem_ack && !w_head.write) ? mem_rdata : '0;
        end
    end

    assign rsp_write = rsp_valid && r_rsp_write;
    assign rsp_rdata = rsp_valid ? r_rsp_rdata : '0;

endmodule

// File: tb/tb_pe_bus_master.sv
// -----------------------------------------------------------------------------
// tb_pe_bus_master
// Purpose : Self-checking bench for pe_bus_master. Stimulus pushes expected
//           bus transfers and PE responses into queues; a monitor pops and
//           compares whenever the DUT acks a transfer or pulses rsp_valid.
//           Build with +define+PE_BUS_TIMEOUT_EN to include the timeout case.
// -----------------------------------------------------------------------------
module tb_pe_bus_master;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic          write;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          bus_request;
    logic          grant;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          rsp_valid;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [CW-1:0] pending;

    int checks = 0;
    int errors = 0;

    bus_exp_t exp_bus[$];
    rsp_exp_t exp_rsp[$];

    // Bus/arbiter responder controls
    logic grant_en    = 1'b1;
    logic grant_force = 1'b0;
    logic ack_en      = 1'b1;
    int   ack_delay   = 0;
    int   strobe_cycles = 0;

    logic [DW-1:0] tb_mem    [1024];
    logic [DW-1:0] model_mem [1024];

    pe_bus_master #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .bus_request (bus_request),
        .grant       (grant),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Memory/arbiter model
    assign grant     = grant_force | (grant_en & bus_request);
    assign mem_ack   = ack_en & (mem_read | mem_write) & (strobe_cycles >= ack_delay);
    assign mem_rdata = tb_mem[mem_address[11:2]];

    always @(posedge clk) begin
        if (mem_read || mem_write) strobe_cycles <= strobe_cycles + 1;
        else                       strobe_cycles <= 0;
        if (mem_write && mem_ack) tb_mem[mem_address[11:2]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares bus transfers at ack and responses at rsp_valid.
    logic prev_rsp_valid = 1'b0;
    always @(negedge clk) begin
        if ((mem_read || mem_write) && mem_ack) begin
            if (exp_bus.size() == 0) begin
                check("unexpected_bus_xfer", 1, 0);
            end else begin
                bus_exp_t e;
                e = exp_bus.pop_front();
                check("bus_write", mem_write, e.write);
                check("bus_read", mem_read, !e.write);
                check("bus_addr", mem_address, e.addr);
                check("bus_wdata", mem_wdata, e.wdata);
            end
        end
        if (rsp_valid) begin
            check("rsp_single_pulse", prev_rsp_valid, 0);
            if (exp_rsp.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                rsp_exp_t r;
                r = exp_rsp.pop_front();
                check("rsp_write", rsp_write, r.write);
                check("rsp_rdata", rsp_rdata, r.rdata);
                check("rsp_err", rsp_err, r.err);
            end
        end
        prev_rsp_valid <= rsp_valid;
    end

    // Issue one request starting at a negedge; returns at the negedge after
    // the accepting clock edge.
    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input bit expect_ack = 1'b1);
        int       n = 0;
        int       idx;
        bus_exp_t b;
        rsp_exp_t r;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready_wait", req_ready, 1);
        idx = int'(addr[11:2]);
        b.write = wr;
        b.addr  = addr;
        b.wdata = wdata;
        r.write = wr;
        r.rdata = (wr || !expect_ack) ? '0 : model_mem[idx];
        r.err   = !expect_ack;
        if (expect_ack) exp_bus.push_back(b);
        exp_rsp.push_back(r);
        if (wr && expect_ack) model_mem[idx] = wdata;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_rsp.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_complete", exp_rsp.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        while (!(mem_read || mem_write) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, mem_read | mem_write, 1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]    = 32'hA500_0000 | i;
            model_mem[i] = 32'hA500_0000 | i;
        end
        tb_mem[10'h040]    = 32'h8765_4321;
        model_mem[10'h040] = 32'h8765_4321;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_bus_request", bus_request, 0);
        check("rst_strobes", {mem_read, mem_write}, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_rsp", {rsp_valid, rsp_write, rsp_err}, 0);
        check("rst_pending", pending, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: load with latency trace
        issue(1'b0, 32'h100, 32'h0);
        check("t1_pending", pending, 1);
        check("t1_idle_no_breq", bus_request, 0);
        @(negedge clk);
        check("t1_breq", bus_request, 1);
        check("t1_no_strobe_in_req", mem_read, 0);
        @(negedge clk);
        check("t1_strobe", mem_read, 1);
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_rdata", rsp_rdata, 32'h8765_4321);
        @(negedge clk);
        check("t1_rsp_one_cycle", rsp_valid, 0);
        drain(20);

        // 2: store with delayed ack, then read it back
        ack_delay = 3;
        issue(1'b1, 32'h200, 32'h02BB_81A3);
        drain(30);
        check("t2_mem_written", tb_mem[10'h080], 32'h02BB_81A3);
        ack_delay = 0;
        issue(1'b0, 32'h200, 32'h0);
        drain(20);

        // 3: fill the FIFO with grant held off
        grant_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) issue(1'b0, 32'h300 + 32'(4 * i), 32'h0);
        check("t3_full_not_ready", req_ready, 0);
        check("t3_pending_full", pending, 4);
        req_valid = 1'b1;
        req_addr  = 32'h400;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = '0;
        check("t3_fifth_refused", pending, 4);
        check("t3_no_strobe", mem_read | mem_write, 0);
        grant_en = 1'b1;
        drain(100);
        check("t3_pending_empty", pending, 0);

        // 4: long grant delay, then a one-cycle grant pulse
        grant_en = 1'b0;
        issue(1'b0, 32'h500, 32'h0);
        @(negedge clk);
        begin
            int bad = 0;
            for (int i = 0; i < 10; i++) begin
                if (!bus_request || mem_read || mem_write) bad++;
                @(negedge clk);
            end
            check("t4_wait_violations", bad, 0);
        end
        grant_force = 1'b1;
        @(negedge clk);
        grant_force = 1'b0;
        check("t4_xfer_after_pulse", mem_read, 1);
        drain(20);
        grant_en = 1'b1;

        // 5: reset while a transfer is in flight
        ack_en = 1'b0;
        issue(1'b0, 32'h600, 32'h0);
        issue(1'b0, 32'h604, 32'h0);
        wait_strobe("t5_reach_xfer");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_breq", bus_request, 0);
        check("t5_strobes", {mem_read, mem_write}, 0);
        check("t5_addr_wdata", {mem_address, mem_wdata}, 0);
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_pending", pending, 0);
        check("t5_req_ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        exp_rsp.delete();
        exp_bus.delete();
        ack_en = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_stays_idle", bus_request, 0);

`ifdef PE_BUS_TIMEOUT_EN
        // 6: timeout with no ack, next request completes normally
        ack_en = 1'b0;
        issue(1'b0, 32'h700, 32'h0, 1'b0);
        wait_strobe("t6_reach_xfer");
        begin
            int n = 0;
            while (mem_read && n < 50) begin
                n++;
                @(negedge clk);
            end
            check("t6_xfer_cycles", n, TMO);
        end
        ack_en = 1'b1;
        issue(1'b0, 32'h704, 32'h0);
        drain(40);
`endif

        check("final_scoreboard_empty", exp_rsp.size() + exp_bus.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
